// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - tightly coupled data RAM responder for the LSU (optional DMEM_MISALIGN_ERR_EN)
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W = DEPTH[ADDR_WIDTH-3:0];

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [3:0]            lat_be;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic                  accept;
  logic                  use_lat;
  logic                  enter_resp;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            cur_be;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [IDX_W-1:0]      word_idx;
  logic                  be_ok;
  logic                  out_of_range;
  logic [3:0]            be_eff;
  logic [1:0]            off_eff;
  logic [3:0]            be_lane;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
`ifdef DMEM_MISALIGN_ERR_EN
  logic [3:0]            be_spill;
`endif

  // While waiting the latched request is the live one; otherwise the bus inputs are
  assign accept     = req_i && gnt_o;
  assign use_lat    = (state == ST_WAIT);
  assign cur_we     = use_lat ? lat_we    : we_i;
  assign cur_addr   = use_lat ? lat_addr  : addr_i;
  assign cur_be     = use_lat ? lat_be    : be_i;
  assign cur_wdata  = use_lat ? lat_wdata : wdata_i;
  assign enter_resp = use_lat ? (cnt == 4'd0) : (accept && (WAIT_STATES == 0));
  assign word_idx   = cur_addr[IDX_W+1:2];

  // Lane placement, alignment handling and error classification for the live request
  always_comb begin
    be_ok        = (cur_be == 4'b0001) || (cur_be == 4'b0011) || (cur_be == 4'b1111);
    out_of_range = (cur_addr[ADDR_WIDTH-1:2] >= DEPTH_W);
`ifdef DMEM_MISALIGN_ERR_EN
    be_eff             = cur_be;
    off_eff            = cur_addr[1:0];
    {be_spill, be_lane} = {4'b0000, be_eff} << off_eff;
    acc_err            = out_of_range || !be_ok || (be_spill != 4'b0000);
`else
    // Invalid enables become a word access; the offset is rounded down to the access size
    be_eff = be_ok ? cur_be : 4'b1111;
    case (be_eff)
      4'b0001: off_eff = cur_addr[1:0];
      4'b0011: off_eff = {cur_addr[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
    be_lane = be_eff << off_eff;
    acc_err = out_of_range;
`endif
    lane_mask = {{8{be_eff[3]}}, {8{be_eff[2]}}, {8{be_eff[1]}}, {8{be_eff[0]}}};
    wr_data   = cur_wdata << {off_eff, 3'b000};
    rd_data   = (mem[word_idx] >> {off_eff, 3'b000}) & lane_mask;
  end

  // Byte-lane RAM write, committed only on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && cur_we && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_lane[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Control FSM with registered grant and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt_o     <= 1'b1;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= 4'd0;
      lat_wdata <= '0;
    end else begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      if (enter_resp) begin
        state    <= ST_RESP;
        gnt_o    <= 1'b1;
        rvalid_o <= 1'b1;
        err_o    <= acc_err;
        rdata_o  <= (cur_we || acc_err) ? '0 : rd_data;
      end else begin
        case (state)
          ST_WAIT: cnt <= cnt - 4'd1;
          default: begin
            if (accept) begin
              state <= ST_WAIT;
              gnt_o <= 1'b0;
              cnt   <= WS_LOAD;
            end else begin
              state <= ST_IDLE;
              gnt_o <= 1'b1;
            end
          end
        endcase
      end
      if (accept) begin
        lat_we    <= we_i;
        lat_addr  <= addr_i;
        lat_be    <= be_i;
        lat_wdata <= wdata_i;
      end
    end
  end

endmodule
